rr_sel_arbiter: RTL and testbench



---
 rtl/rr_sel_arbiter.sv | 97 +++++++++
 tb/tb_rr_sel_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving the select input of an N-to-1 mux.
// Holds one owner until done, request drop, or hold timeout, then rotates priority.
module rr_sel_arbiter #(
  parameter int N        = 4,
  parameter int SELW     = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            timeout
);

  // state | meaning
  // IDLE  | no owner; arbitrate among req from ptr upward
  // HOLD  | grant held for sel until done, req drop or hold timeout
  typedef enum logic {IDLE, HOLD} state_t;

  localparam int CW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(HOLD_MAX);
  localparam logic [CW-1:0]   CNT_LAST = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);
  localparam logic [SELW:0]   N_W      = (SELW + 1)'(N);

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [CW-1:0]   cnt;

  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;
  logic [SELW-1:0] win;
  logic            rel_done;
  logic            rel_drop;
  logic            rel_tmo;

  // Rotate requests so bit 0 is the ptr position; the lowest set bit wins.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = SELW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    win = sum[SELW-1:0];
  end

  always_comb begin
    rel_done = done;
    rel_drop = ~req[sel];
    rel_tmo  = (HOLD_MAX != 0) && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (|req) begin
            state <= HOLD;
            sel   <= win;
            grant <= {{(N-1){1'b0}}, 1'b1} << win;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (rel_done || rel_drop || rel_tmo) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            ptr     <= (sel == LAST_IDX) ? '0 : sel + SELW'(1);
            timeout <= rel_tmo && !rel_done && !rel_drop;
          end else begin
            timeout <= 1'b0;
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios plus random traffic against a
// transaction-level model (owner, last winner, cycles held).
module tb_rr_sel_arbiter;
  localparam int N        = 4;
  localparam int SELW     = 2;
  localparam int HOLD_MAX = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic            done;
  logic [SELW-1:0] sel;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout;

  int tests;
  int fails;

  // model: owner index valid while m_busy; m_last is the previous winner
  bit m_busy;
  int m_sel;
  int m_last;
  int m_held;
  bit m_to;

  rr_sel_arbiter #(.N(N), .SELW(SELW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .grant(grant), .busy(busy), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_sel  = 0;
    m_last = N - 1;
    m_held = 0;
    m_to   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic d);
    bit found;
    bit tmo;
    if (!m_busy) begin
      m_to = 0;
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (!found && r[idx]) begin
          found = 1;
          m_sel = idx;
        end
      end
      if (found) begin
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      tmo = (HOLD_MAX != 0) && (m_held == HOLD_MAX);
      if (d || !r[m_sel] || tmo) begin
        m_to   = tmo && !d && r[m_sel];
        m_busy = 0;
        m_last = m_sel;
      end else begin
        m_to   = 0;
        m_held = m_held + 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_sel) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic d);
    @(negedge clk);
    check_outputs();
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rr;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    do_reset();

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      cycle('0, 1'b0);
      #1;
      chk("t1_idle_grant", 32'(grant), 32'h0);
      chk("t1_idle_sel", 32'(sel), 32'h0);
    end

    // first grant from ptr=0, done release, then next requester
    cycle(4'b0101, 1'b0);
    #1;
    chk("t2_grant0", 32'(grant), 32'h1);
    chk("t2_busy", 32'(busy), 32'h1);
    cycle(4'b0101, 1'b1);
    #1;
    chk("t2_release", 32'(grant), 32'h0);
    cycle(4'b0101, 1'b0);
    #1;
    chk("t2_grant2", 32'(grant), 32'h4);
    chk("t2_sel2", 32'(sel), 32'h2);
    cycle(4'b0101, 1'b1);

    // full rotation with wrap-around
    do_reset();
    for (int g = 0; g < 5; g++) begin
      cycle(4'b1111, 1'b0);
      #1;
      chk("t3_sel", 32'(sel), 32'(g % N));
      chk("t3_busy", 32'(busy), 32'h1);
      cycle(4'b1111, 1'b1);
      #1;
      chk("t3_gap", 32'(busy), 32'h0);
    end

    // hold timeout with a single persistent requester
    cycle(4'b0010, 1'b0);
    for (int i = 0; i < HOLD_MAX; i++) begin
      #1;
      chk("t4_held", 32'(busy), 32'h1);
      chk("t4_sel", 32'(sel), 32'h1);
      cycle(4'b0010, 1'b0);
    end
    #1;
    chk("t4_timeout", 32'(timeout), 32'h1);
    chk("t4_busy", 32'(busy), 32'h0);
    cycle(4'b0010, 1'b0);
    #1;
    chk("t4_regrant", 32'(grant), 32'h2);
    chk("t4_to_clr", 32'(timeout), 32'h0);
    cycle(4'b0000, 1'b0);
    #1;
    chk("t4_drop_to", 32'(timeout), 32'h0);

    // owner drops its request
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    #1;
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_timeout", 32'(timeout), 32'h0);
    chk("t5_sel", 32'(sel), 32'h2);

    // async reset during a hold
    cycle(4'b1000, 1'b0);
    #1;
    chk("t6_grant3", 32'(grant), 32'h8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_sel", 32'(sel), 32'h0);
    req  = '0;
    done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001, 1'b0);
    #1;
    chk("t6_ptr0", 32'(grant), 32'h1);
    cycle(4'b1001, 1'b1);

    // random traffic with sticky requests
    rr = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rr = N'($urandom_range(0, (1 << N) - 1));
      cycle(rr, $urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
